id_ex_hazard_ctrl: RTL

//  Pipeline sequencer for the IF/ID and ID/EX stages of the 5-stage MIPS core. Detects load-use

---
 rtl/id_ex_hazard_ctrl_pkg.sv | 35 +++
 rtl/id_ex_hazard_ctrl_if.sv | 36 +++
 rtl/id_ex_hazard_ctrl_hazard_detect.sv | 26 ++
 rtl/id_ex_hazard_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared types and constants for the IF/ID / ID/EX pipeline sequencer.
package id_ex_hazard_ctrl_pkg;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned LU_W     = 3;
    localparam int unsigned WAIT_W   = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic idex_bubble;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RUN   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctl_t CTL_STALL = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctl_t CTL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctl_t CTL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctl_t CTL_RESET = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Saturating increment for the memory-wait counter.
    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
        return (v == '1) ? v : v + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// Decode-side control bus between the ID stage and the pipeline sequencer.
interface id_ex_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             branch_taken;
    logic             mem_busy;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             idex_bubble;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_timeout;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, branch_taken, mem_busy,
        input  pc_write, ifid_write, idex_write, idex_bubble,
               flush_ifid, flush_idex, flush_exmem, stall_cnt, mem_timeout
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, branch_taken, mem_busy,
        output pc_write, ifid_write, idex_write, idex_bubble,
               flush_ifid, flush_idex, flush_exmem, stall_cnt, mem_timeout
    );
endinterface

// File: rtl/id_ex_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction reading the register a load in EX is producing.
module hazard_detect
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    output logic             hazard_c
);

    logic rs_match_c;
    logic rt_match_c;

    assign rs_match_c = (ex_rt == id_rs);
    assign rt_match_c = id_uses_rt && (ex_rt == id_rt);

    // $zero is hardwired, so a load targeting it never creates a dependency.
    assign hazard_c = id_valid && ex_memread && (ex_rt != REG_W'(REG_ZERO))
                      && (rs_match_c || rt_match_c);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// IF/ID and ID/EX sequencer: load-use bubbles, branch flush, memory-busy freeze, stall counter.
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input logic                clk,
    input logic                rst,
    id_ex_hazard_ctrl_if.slave bus
);

    localparam logic [LU_W-1:0]   LU_RELOAD  = LU_W'(LOAD_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    state_t            eff_state_c;
    logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              hazard_c;
    pipe_ctl_t         ctl_c;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_valid   (bus.id_valid),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .ex_memread (bus.ex_memread),
        .ex_rt      (bus.ex_rt),
        .hazard_c   (hazard_c)
    );

    // Next-state and control decode; priority is mem_busy > branch_taken > load-use.
    always_comb begin
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        mem_timeout_d = mem_timeout_q;
        ctl_c         = CTL_RUN;
        eff_state_c   = state_q;

        // The cycle leaving MEM_WAIT behaves as the state that was interrupted.
        if (state_q == ST_MEM_WAIT) begin
            eff_state_c = (lu_cnt_q != '0) ? ST_LU_STALL : ST_RUN;
        end

        if (bus.mem_busy) begin
            ctl_c      = CTL_HOLD;
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = (state_q == ST_MEM_WAIT) ? wait_inc(wait_cnt_q) : WAIT_W'(1);
            if (wait_cnt_d >= WAIT_LIMIT) begin
                mem_timeout_d = 1'b1;
            end
        end else begin
            wait_cnt_d = '0;
            if (bus.branch_taken) begin
                ctl_c    = CTL_FLUSH;
                lu_cnt_d = '0;
                state_d  = ST_RUN;
            end else if (eff_state_c == ST_LU_STALL) begin
                ctl_c    = CTL_STALL;
                lu_cnt_d = lu_cnt_q - LU_W'(1);
                state_d  = (lu_cnt_d == '0) ? ST_RUN : ST_LU_STALL;
            end else if (hazard_c) begin
                ctl_c = CTL_STALL;
                if (LOAD_LAT > 1) begin
                    lu_cnt_d = LU_RELOAD;
                    state_d  = ST_LU_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                state_d = ST_RUN;
            end
        end

        if (!ctl_c.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (rst) begin
            ctl_c = CTL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            lu_cnt_q      <= '0;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lu_cnt_q      <= lu_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign bus.pc_write    = ctl_c.pc_write;
    assign bus.ifid_write  = ctl_c.ifid_write;
    assign bus.idex_write  = ctl_c.idex_write;
    assign bus.idex_bubble = ctl_c.idex_bubble;
    assign bus.flush_ifid  = ctl_c.flush_ifid;
    assign bus.flush_idex  = ctl_c.flush_idex;
    assign bus.flush_exmem = ctl_c.flush_exmem;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.mem_timeout = mem_timeout_q;

endmodule
